uart_rx: RTL and testbench

//  Receive half of the UART link; consumes the serial stream produced by Top_UART_Tx (o_tx_d).

---
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1, idle-high line, 2-flop synchroniser, mid-bit sampling.
// Delivers each good byte with a one-cycle valid strobe and flags a zero stop bit with a one-cycle error strobe.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx_d,
    output logic [7:0] o_rx_d,
    output logic       o_rx_valid,
    output logic       o_rx_frame_err,
    output logic       o_rx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             s1_q, rx_s_q;

    // Synchroniser flops reset high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            s1_q   <= i_rx_d;
            rx_s_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leaving mid stop bit leaves half a bit of slack for a back-to-back start edge.
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            BRK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_rx_d         = data_q;
    assign o_rx_valid     = valid_q;
    assign o_rx_frame_err = ferr_q;
    assign o_rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a serial line driver pushes expected strobes into a queue,
// and a monitor pops and compares them whenever the receiver strobes valid or frame error.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned CPB      = 434;
    localparam int unsigned CPB_FAST = 425;   // transmitter 2% fast
    localparam int unsigned HALF     = 217;
    localparam int unsigned LAT      = 4126;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] o_rx_d;
    logic       o_rx_valid;
    logic       o_rx_frame_err;
    logic       o_rx_busy;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx_d        (rx),
        .o_rx_d        (o_rx_d),
        .o_rx_valid    (o_rx_valid),
        .o_rx_frame_err(o_rx_frame_err),
        .o_rx_busy     (o_rx_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned t0;
        bit          chk_lat;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         passes = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_lat(input int lat);
        checks++;
        if (lat >= int'(LAT) - 2 && lat <= int'(LAT) + 2) passes++;
        else $display("FAIL strobe_latency: got %0d expected %0d+-2", lat, LAT);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (o_rx_valid || o_rx_frame_err)) begin
            chk("valid_err_exclusive", int'(o_rx_valid & o_rx_frame_err), 0);
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe: got valid=%0b err=%0b data=%0h expected none",
                         o_rx_valid, o_rx_frame_err, o_rx_d);
            end else begin
                e = sbq.pop_front();
                chk("strobe_kind_err", int'(o_rx_frame_err), int'(e.is_err));
                chk("rx_data", int'(o_rx_d), int'(e.data));
                if (e.chk_lat) chk_lat(int'(cyc - e.t0));
            end
        end
    end

    // Called at a negedge; returns at the negedge where the next start bit may begin.
    task automatic send(input logic [7:0] b, input bit stop, input int unsigned cpb,
                        input bit chk_latency);
        exp_t e;
        e.is_err  = !stop;
        e.data    = stop ? b : last_good;
        e.t0      = cyc;
        e.chk_lat = chk_latency;
        sbq.push_back(e);
        if (stop) last_good = b;
        rx = 1'b0;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cpb) @(negedge clk);
        end
        rx = stop;
        repeat (cpb) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_d"}, int'(o_rx_d), 0);
        chk({tag, "_valid"}, int'(o_rx_valid), 0);
        chk({tag, "_frame_err"}, int'(o_rx_frame_err), 0);
        chk({tag, "_busy"}, int'(o_rx_busy), 0);
    endtask

    initial begin
        int unsigned k;
        logic [7:0]  partial;

        // 1: reset, then idle line
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk_reset_outputs("idle");

        // 2: single byte with latency check
        send(8'h55, 1'b1, CPB, 1'b1);
        repeat (CPB) @(negedge clk);

        // 3: back-to-back bytes, no idle gap
        send(8'h00, 1'b1, CPB, 1'b1);
        send(8'hFF, 1'b1, CPB, 1'b1);
        send(8'hA5, 1'b1, CPB, 1'b1);
        repeat (CPB) @(negedge clk);

        // 4: start glitch of 100 clocks
        k  = cyc;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy_high", int'(o_rx_busy), 1);
        repeat (90) @(negedge clk);
        rx = 1'b1;
        repeat (HALF + 3 - 100) @(negedge clk);
        chk("glitch_elapsed", int'(cyc - k), int'(HALF + 3));
        chk("glitch_busy_low", int'(o_rx_busy), 0);
        repeat (CPB) @(negedge clk);

        // 5: zero stop bit, then a good byte
        send(8'h3C, 1'b0, CPB, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        chk("ferr_keeps_rx_d", int'(o_rx_d), int'(8'hA5));
        send(8'hC3, 1'b1, CPB, 1'b1);
        repeat (CPB) @(negedge clk);

        // 6: reset during data bit 4, then a frame from a 2% fast transmitter
        partial = 8'h5A;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx = partial[i];
            repeat (CPB / 2) @(negedge clk);
            if (i < 4) repeat (CPB - CPB / 2) @(negedge clk);
        end
        chk("midframe_busy", int'(o_rx_busy), 1);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("midframe_reset");
        last_good = 8'h00;
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("post_reset_busy", int'(o_rx_busy), 0);
        send(8'h81, 1'b1, CPB_FAST, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("fast_rx_d", int'(o_rx_d), int'(8'h81));

        chk("outstanding_strobes", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
